mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares one synchronous single-port memory (1-cycle read latency) between two requesters:
//   port 0 = processor bus (ADDR/DOUT/W side), port 1 = secondary master (loader/DMA/debug).
//   Per-port req/gnt handshake, round-robin or fixed priority, read data returned with rvalid.
//   Sits between the processor and the memory; memory-side outputs are registered.
// PARAMETERS
//   ADDR_W      16  address width, both ports and memory
//   DATA_W      16  data width
//   FIXED_PRIO  0   0 = round-robin on ties; 1 = port 0 always wins ties
// PORTS
//   Clock       in   1       system clock, rising edge
//   Resetn      in   1       asynchronous, active-low reset
//   req0        in   1       port 0 access request; held until gnt0
//   we0         in   1       port 0: 1 = write, 0 = read; stable while req0
//   addr0       in   ADDR_W  port 0 address; stable while req0
//   wdata0      in   DATA_W  port 0 write data; stable while req0
//   gnt0        out  1       port 0 request accepted (1-cycle pulse)
//   rvalid0     out  1       port 0 read data valid on rdata0 (1-cycle pulse)
//   rdata0      out  DATA_W  port 0 read data (= mem_q; qualify with rvalid0)
//   req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   same as port 0, for port 1
//   mem_addr    out  ADDR_W  memory address (registered)
//   mem_wdata   out  DATA_W  memory write data (registered)
//   mem_wren    out  1       memory write enable (registered)
//   mem_q       in   DATA_W  memory read data, valid 1 cycle after the address edge
// BEHAVIOUR
//   Reset: state=IDLE, gnt*/rvalid*/mem_wren=0, mem_addr/mem_wdata=0, owner=0, last=1.
//   FSM: IDLE -> BUSY -> DONE; DONE -> BUSY (new req) or IDLE.
//   - IDLE/DONE: if req0|req1, pick winner; on edge latch addr/wdata/we into mem_*, owner<=winner,
//     last<=winner, -> BUSY. No req: -> IDLE. The loser's req stays pending.
//   - BUSY (exactly 1 cycle): gnt_owner=1; mem_wren=1 only for a write; req not sampled; -> DONE.
//   - DONE: mem_wren=0; for a read, rvalid_owner=1 with rdata=mem_q; no rvalid for a write.
//     Arbitrates in the same cycle (pipelined): back-to-back accesses every 2 cycles.
//   Pick: only one req -> that port. Both: FIXED_PRIO=1 -> port 0; else the port != last.
//   Requester must drop or change req on the edge ending its gnt cycle. A req still high in DONE
//   is treated as a new access.
//   Read latency: req seen at edge k -> gnt in cycle k+1 -> rvalid in cycle k+2.
//   Write completes at the edge ending BUSY; never more than one access in flight.
//   Port 1 continuous req with round-robin: grants alternate 0,1,0,1; no starvation.
//   Reset mid-access: aborts immediately (async); mem_wren drops, no gnt/rvalid follow.
//   Widths: no arithmetic; addresses passed unmodified; no wrap or range checks.
// STRUCTURE
//   Shared header arb_defs.vh: state encodings (IDLE/BUSY/DONE), port ids P0=0/P1=1.
//   One sub-module: rr_pick2 (combinational, in: req0, req1, last, fixed; out: valid, winner).
//   The FSM, owner/last registers and mem_* registers live in mem_arbiter.
// TESTING
//   1 Read: req0=1,we0=0,addr0=0x0010, mem[0x10]=0xBEEF -> gnt0 next cycle, rvalid0 cycle after,
//     rdata0=0xBEEF; port 1 silent.
//   2 Write: req1=1,we1=1,addr1=0x0020,wdata1=0x1234 -> mem_wren=1 for one cycle with
//     mem_addr=0x0020, mem_wdata=0x1234; gnt1 pulse; no rvalid1; readback gives 0x1234.
//   3 Tie after reset, both held high, FIXED_PRIO=0 -> gnt order 0,1,0,1; a grant every 2 cycles.
//   4 Same with FIXED_PRIO=1 -> port 0 granted every time; port 1 granted only once req0 drops.
//   5 Back-to-back reads on port 0 (req changed on gnt) -> rvalid0 every 2 cycles, data in order.
//   6 Resetn low during BUSY of a write -> mem_wren=0 at once, no rvalid; after release: IDLE,
//     first tie goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Arbiter FSM states: IDLE waits, BUSY drives the access, DONE returns data and re-arbitrates
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Port identifiers used for owner/last bookkeeping
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: req/we/addr/wdata in, gnt/rvalid/rdata back.
// Latency: gnt one cycle after req is sampled, rvalid one cycle after gnt (reads only).
// Backpressure: requester holds req and its payload stable until gnt.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way request picker: fixed priority to port 0, or round-robin against the last winner.
// Latency: purely combinational.
// Backpressure: none; the losing request simply stays pending upstream.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic fixed,
  output logic valid,
  output logic winner
);

  // A single request always wins; a tie goes to port 0 when fixed, else to the port that did not win last
  always_comb begin
    valid  = req0 | req1;
    winner = P0;
    if (req0 && req1) begin
      winner = fixed ? P0 : ~last;
    end else if (req1) begin
      winner = P1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read) between two requesters.
// Latency: req sampled at edge k -> gnt in cycle k+1 -> rvalid (reads) in cycle k+2.
// Backpressure: one access in flight; a pending request waits until the FSM leaves BUSY.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
)(
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      p0,
  mem_arbiter_if.slave      p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  state_t state;
  state_t state_nxt;
  logic   owner;      // port that owns the access currently in BUSY/DONE
  logic   last;       // port that won the most recent arbitration
  logic   wr_q;       // owner's access is a write (suppresses rvalid in DONE)
  logic   pick_vld;
  logic   pick_win;
  logic   take;

  rr_pick2 u_pick (
    .req0   (p0.req),
    .req1   (p1.req),
    .last   (last),
    .fixed  (FIXED_PRIO),
    .valid  (pick_vld),
    .winner (pick_win)
  );

  // Requests are only sampled outside BUSY, so DONE overlaps with the next arbitration
  assign take = (state != BUSY) && pick_vld;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: BUSY lasts exactly one cycle; IDLE/DONE start a new access on any request
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_vld ? BUSY : IDLE;
      BUSY:    state_nxt = DONE;
      DONE:    state_nxt = pick_vld ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's access into the registered memory interface; wren lives only for BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= P0;
      last      <= P1;
      wr_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (take) begin
        owner     <= pick_win;
        last      <= pick_win;
        wr_q      <= pick_win ? p1.we : p0.we;
        mem_addr  <= pick_win ? p1.addr : p0.addr;
        mem_wdata <= pick_win ? p1.wdata : p0.wdata;
        mem_wren  <= pick_win ? p1.we : p0.we;
      end
    end
  end

  // Outputs: gnt to the owner during BUSY, rvalid to the owner of a read during DONE
  always_comb begin
    p0.gnt    = (state == BUSY) && (owner == P0);
    p1.gnt    = (state == BUSY) && (owner == P1);
    p0.rvalid = (state == DONE) && !wr_q && (owner == P0);
    p1.rvalid = (state == DONE) && !wr_q && (owner == P1);
    p0.rdata  = mem_q;
    p1.rdata  = mem_q;
  end

endmodule
